// File: rtl/result_rd_arbiter.sv
// Round-robin arbiter and burst sequencer for the result RAM read port.
// Interlocks result saves so they never land inside a read burst.
module result_rd_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned IDW       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  input  logic               save_req,
  output logic               save_ack,
  output logic               ram_save_sop,
  output logic               ram_rd_sop,
  input  logic               ram_rd_vld,
  input  logic               ram_rd_eop,
  input  logic [DW-1:0]      ram_rd_data,
  output logic               out_vld,
  output logic               out_eop,
  output logic [DW-1:0]      out_data,
  output logic [IDW-1:0]     out_id
);

  localparam int unsigned BCW = $clog2(BURST_LEN) + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gid;
  logic [BCW-1:0]     bcnt;
  logic [TCW-1:0]     tcnt;

  logic               found_c;
  logic [IDW-1:0]     pick_c;
  logic [NUM_REQ-1:0] onehot_c;
  logic [BCW-1:0]     bcnt_nx_c;
  logic               len_hit_c;

  // First asserted request strictly after the RR pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    found_c  = 1'b0;
    pick_c   = rr_ptr;
    onehot_c = '0;
    idx      = rr_ptr;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        pick_c  = idx;
      end
    end
    onehot_c[pick_c] = 1'b1;
  end

  assign bcnt_nx_c = bcnt + BCW'(1);
  assign len_hit_c = (bcnt_nx_c == BCW'(BURST_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= IDW'(NUM_REQ - 1);
      gid          <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      save_ack     <= 1'b0;
      ram_save_sop <= 1'b0;
      ram_rd_sop   <= 1'b0;
      out_vld      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      out_id       <= '0;
    end else begin
      done         <= '0;
      err          <= 1'b0;
      save_ack     <= 1'b0;
      ram_save_sop <= 1'b0;
      ram_rd_sop   <= 1'b0;
      out_vld      <= 1'b0;
      out_eop      <= 1'b0;
      case (state)
        // A held save_req is not re-served in the cycle its ack is showing.
        IDLE: begin
          if (!ram_rd_vld) begin
            if (save_req && !save_ack) begin
              ram_save_sop <= 1'b1;
              save_ack     <= 1'b1;
            end else if (found_c) begin
              gnt        <= onehot_c;
              gid        <= pick_c;
              ram_rd_sop <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bcnt  <= '0;
          tcnt  <= '0;
          state <= BURST;
        end
        BURST: begin
          if (ram_rd_vld) begin
            out_vld  <= 1'b1;
            out_data <= ram_rd_data;
            out_id   <= gid;
            out_eop  <= ram_rd_eop || len_hit_c;
            bcnt     <= bcnt_nx_c;
            tcnt     <= '0;
            if (ram_rd_eop || len_hit_c) begin
              err       <= ram_rd_eop ? !len_hit_c : 1'b1;
              done[gid] <= 1'b1;
              gnt       <= '0;
              rr_ptr    <= gid;
              state     <= DRAIN;
            end
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            done[gid] <= 1'b1;
            gnt       <= '0;
            rr_ptr    <= gid;
            state     <= DRAIN;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        DRAIN: begin
          if (!ram_rd_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_rd_arbiter.sv
// Scoreboard bench for result_rd_arbiter with a behavioural burst RAM.
module tb_result_rd_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DW        = 16;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned IDW       = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic               err;
  logic               save_req;
  logic               save_ack;
  logic               ram_save_sop;
  logic               ram_rd_sop;
  logic               ram_rd_vld;
  logic               ram_rd_eop;
  logic [DW-1:0]      ram_rd_data;
  logic               out_vld;
  logic               out_eop;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;

  result_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .DW(DW), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .err(err),
    .save_req(save_req), .save_ack(save_ack), .ram_save_sop(ram_save_sop),
    .ram_rd_sop(ram_rd_sop), .ram_rd_vld(ram_rd_vld), .ram_rd_eop(ram_rd_eop),
    .ram_rd_data(ram_rd_data), .out_vld(out_vld), .out_eop(out_eop),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic gnt_multi = 1'b0;

  typedef struct {
    logic           vld;
    logic           eop;
    logic [IDW-1:0] id;
    logic [NUM_REQ-1:0] dn;
    logic           er;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t sbq[$];

  // RAM model configuration, latched when it sees rd_sop
  int          cfg_nbeats = 8;
  int          cfg_eop    = 7;
  logic [DW-1:0] cfg_base = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ram_cfg(input int nb, input int eidx, input logic [DW-1:0] base);
    cfg_nbeats = nb;
    cfg_eop    = eidx;
    cfg_base   = base;
  endtask

  // Expected forwarded beats for one burst; last item carries done/err.
  task automatic push_burst(input int id, input logic [DW-1:0] base, input int nb, input int eidx);
    exp_t e;
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    if (nb == 0) begin
      e = '{vld: 1'b0, eop: 1'b0, id: '0, dn: oh, er: 1'b1, data: '0};
      sbq.push_back(e);
    end else begin
      for (int i = 0; i < nb; i++) begin
        logic last;
        last = (i == eidx) || (i == int'(BURST_LEN) - 1);
        e.vld  = 1'b1;
        e.eop  = last;
        e.id   = IDW'(id);
        e.dn   = last ? oh : '0;
        e.er   = last ? ((i == eidx) ? (i + 1 != int'(BURST_LEN)) : 1'b1) : 1'b0;
        e.data = base + DW'(i);
        sbq.push_back(e);
        if (last) break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    chk("reset_outputs",
        {gnt, done, err, save_ack, ram_save_sop, ram_rd_sop, out_vld, out_eop, out_data, out_id},
        '0);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_sop(input int limit);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!ram_rd_sop && n < limit);
    if (!ram_rd_sop) begin
      checks++;
      failures++;
      $display("FAIL wait_sop no rd_sop within %0d cycles", limit);
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (done == '0 && n < limit);
    if (done == '0) begin
      checks++;
      failures++;
      $display("FAIL wait_done no done within %0d cycles", limit);
    end
  endtask

  // Burst RAM: beat i is presented i+1 cycles after the cycle it saw rd_sop
  initial begin
    int nb;
    int ei;
    logic [DW-1:0] bs;
    ram_rd_vld  = 1'b0;
    ram_rd_eop  = 1'b0;
    ram_rd_data = '0;
    forever begin
      @(negedge clk);
      if (ram_rd_sop) begin
        nb = cfg_nbeats;
        ei = cfg_eop;
        bs = cfg_base;
        for (int i = 0; i < nb; i++) begin
          @(negedge clk);
          ram_rd_vld  = 1'b1;
          ram_rd_eop  = (i == ei);
          ram_rd_data = bs + DW'(i);
        end
        @(negedge clk);
        ram_rd_vld = 1'b0;
        ram_rd_eop = 1'b0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a beat or a done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ($countones(gnt) > 1) gnt_multi = 1'b1;
      if (out_vld || done != '0 || err) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected vld=%0b data=%0h id=%0d done=%0b err=%0b",
                   out_vld, out_data, out_id, done, err);
        end else begin
          e = sbq.pop_front();
          chk("sb_beat",
              {out_vld, out_eop, out_vld ? out_id : IDW'(0), done, err, out_vld ? out_data : DW'(0)},
              {e.vld, e.eop, e.id, e.dn, e.er, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned prev;
    logic seen;
    rst = 1'b1;
    req = '0;
    save_req = 1'b0;

    // Single read, consumer 0
    do_reset();
    ram_cfg(8, 7, 16'h0010);
    push_burst(0, 16'h0010, 8, 7);
    req = 4'b0001;
    tick(1);
    chk("t1_sop_gnt", {ram_rd_sop, gnt}, {1'b1, 4'b0001});
    tick(1);
    chk("t1_sop_pulse", ram_rd_sop, 0);
    tick(1);
    chk("t1_first_beat", {out_vld, out_data}, {1'b1, 16'h0010});
    tick(7);
    chk("t1_done", {out_eop, done, err, gnt}, {1'b1, 4'b0001, 1'b0, 4'b0000});
    req = '0;
    tick(3);

    // Round robin with all requests held
    do_reset();
    ram_cfg(8, 7, 16'h0200);
    for (int k = 0; k < 5; k++) push_burst(k % 4, 16'h0200, 8, 7);
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      logic [NUM_REQ-1:0] eg;
      wait_sop(40);
      if (k == 4) req = '0;
      eg = '0;
      eg[k % 4] = 1'b1;
      chk("rr_grant", gnt, eg);
      if (k > 0) chk("rr_spacing", 64'(cyc - prev), 11);
      prev = cyc;
    end
    wait_done(20);
    tick(3);

    // Save raised mid-burst waits for IDLE
    ram_cfg(8, 7, 16'h0300);
    push_burst(2, 16'h0300, 8, 7);
    req = 4'b0100;
    tick(1);
    chk("t3_gnt", {ram_rd_sop, gnt}, {1'b1, 4'b0100});
    tick(4);
    save_req = 1'b1;
    seen = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      tick(1);
      if (ram_save_sop || save_ack) seen = 1'b1;
      if (c == 10) begin
        chk("t3_done", done, 4'b0100);
        req = '0;
      end
    end
    chk("t3_no_save_in_burst", seen, 0);
    tick(1);
    chk("t3_save", {ram_save_sop, save_ack}, 2'b11);
    save_req = 1'b0;
    tick(1);
    chk("t3_save_once", ram_save_sop, 0);

    // Save and read together: save first, grant next cycle
    ram_cfg(8, 7, 16'h0400);
    push_burst(3, 16'h0400, 8, 7);
    save_req = 1'b1;
    req = 4'b1000;
    tick(1);
    chk("t3b_save_first", {save_ack, ram_save_sop, gnt}, {1'b1, 1'b1, 4'b0000});
    tick(1);
    chk("t3b_gnt_next", {gnt, ram_rd_sop, ram_save_sop}, {4'b1000, 1'b1, 1'b0});
    save_req = 1'b0;
    tick(9);
    chk("t3b_done", done, 4'b1000);
    req = '0;
    tick(3);

    // Timeout: RAM never answers
    ram_cfg(0, -1, 16'h0000);
    push_burst(0, 16'h0000, 0, -1);
    req = 4'b0001;
    tick(17);
    chk("t4_not_yet", done, 0);
    tick(1);
    chk("t4_timeout", {done, err, gnt, out_vld}, {4'b0001, 1'b1, 4'b0000, 1'b0});
    req = '0;
    tick(2);

    // Early eop on beat 5
    ram_cfg(6, 5, 16'h0600);
    push_burst(1, 16'h0600, 6, 5);
    req = 4'b0010;
    tick(8);
    chk("t5_short", {out_vld, out_eop, out_data, done, err},
        {1'b1, 1'b1, 16'h0605, 4'b0010, 1'b1});
    req = '0;
    tick(3);

    // Eight beats with no eop: forced eop, err
    ram_cfg(8, -1, 16'h0700);
    push_burst(2, 16'h0700, 8, -1);
    req = 4'b0100;
    tick(10);
    chk("t5_no_eop", {out_eop, out_data, done, err}, {1'b1, 16'h0707, 4'b0100, 1'b1});
    req = '0;
    tick(3);

    // Reset at beat 3 while the RAM keeps streaming
    ram_cfg(8, 7, 16'h0800);
    push_burst(1, 16'h0800, 3, -1);
    req = 4'b0010;
    tick(5);
    chk("t6_beat2", {out_vld, out_data}, {1'b1, 16'h0802});
    rst = 1'b1;
    tick(1);
    chk("t6_reset_clear",
        {gnt, done, err, save_ack, ram_save_sop, ram_rd_sop, out_vld, out_eop, out_data, out_id},
        '0);
    rst = 1'b0;
    ram_cfg(8, 7, 16'h0900);
    push_burst(1, 16'h0900, 8, 7);
    seen = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      tick(1);
      if (ram_rd_sop) seen = 1'b1;
    end
    chk("t6_no_reissue", seen, 0);
    tick(1);
    chk("t6_reissue", {ram_rd_sop, gnt}, {1'b1, 4'b0010});
    tick(9);
    chk("t6_done", {done, err}, {4'b0010, 1'b0});
    req = '0;
    tick(5);

    chk("sb_empty", 64'(sbq.size()), 0);
    chk("gnt_onehot", gnt_multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
